// File: rtl/mult_scheduler_pkg.sv
// Shared constants and types for the two-requester multiply scheduler.
package mult_scheduler_pkg;

   localparam int STAGES = 3;
   localparam int NREQ   = 2;
   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef logic [OP_W-1:0]   operand_t;
   typedef logic [PROD_W-1:0] product_t;

   // Round-robin pointer: names the requester that wins a tie.
   typedef enum logic {
      PTR_REQ0 = 1'b0,
      PTR_REQ1 = 1'b1
   } ptr_e;

   // After granting requester gid, the other requester becomes preferred.
   function automatic ptr_e ptr_after_grant(input logic gid);
      ptr_e nxt;
      if (gid) begin
         nxt = PTR_REQ0;
      end else begin
         nxt = PTR_REQ1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mult_scheduler_pipelined_multiplier.sv
// 3-stage 4x4 unsigned multiplier; data stages carry no reset and are
// qualified downstream by a separate valid pipe.
module pipelined_multiplier
   import mult_scheduler_pkg::*;
(
   input  logic              clk,
   input  logic [OP_W-1:0]   x,
   input  logic [OP_W-1:0]   y,
   output logic [PROD_W-1:0] p
);

   logic [5:0]        pp_lo_q, pp_lo_d;
   logic [5:0]        pp_hi_q, pp_hi_d;
   logic [PROD_W-1:0] sum_q, sum_d;
   logic [PROD_W-1:0] p_q, p_d;

   // Split the multiplier into two 2-bit halves, then recombine with a shift.
   always_comb begin
      pp_lo_d = {2'b00, x} * {4'b0000, y[1:0]};
      pp_hi_d = {2'b00, x} * {4'b0000, y[3:2]};
      sum_d   = {2'b00, pp_lo_q} + {pp_hi_q, 2'b00};
      p_d     = sum_q;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      pp_lo_q <= pp_lo_d;
      pp_hi_q <= pp_hi_d;
      sum_q   <= sum_d;
      p_q     <= p_d;
   end

   assign p = p_q;

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one pipelined 4x4 multiplier between two
// requesters, with result tagging and per-requester completion counters.
module mult_scheduler
   import mult_scheduler_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       req_valid,
   input  logic [3:0]       a0,
   input  logic [3:0]       b0,
   input  logic [3:0]       a1,
   input  logic [3:0]       b1,
   output logic [1:0]       req_ready,
   output logic             res_valid,
   output logic             res_id,
   output logic [7:0]       res_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [1:0]        grant_s;
   logic              grant_id_s;
   logic              any_grant_s;
   logic [OP_W-1:0]   mul_x_s;
   logic [OP_W-1:0]   mul_y_s;
   logic [PROD_W-1:0] mul_p_s;

   ptr_e              ptr_q, ptr_d;
   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] id_q, id_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;

   // Arbiter: the pointer only breaks ties; a lone valid requester always wins.
   always_comb begin
      grant_s    = 2'b00;
      grant_id_s = 1'b0;
      if (rst_n && en) begin
         if (req_valid == 2'b11) begin
            if (ptr_q == PTR_REQ1) begin
               grant_s    = 2'b10;
               grant_id_s = 1'b1;
            end else begin
               grant_s    = 2'b01;
               grant_id_s = 1'b0;
            end
         end else if (req_valid == 2'b01) begin
            grant_s    = 2'b01;
            grant_id_s = 1'b0;
         end else if (req_valid == 2'b10) begin
            grant_s    = 2'b10;
            grant_id_s = 1'b1;
         end else begin
            grant_s    = 2'b00;
            grant_id_s = 1'b0;
         end
      end else begin
         grant_s    = 2'b00;
         grant_id_s = 1'b0;
      end
   end

   assign any_grant_s = |grant_s;
   assign req_ready   = grant_s;

   // Operand mux feeding the multiplier in the grant cycle.
   always_comb begin
      mul_x_s = 4'd0;
      mul_y_s = 4'd0;
      case (grant_s)
         2'b01: begin
            mul_x_s = a0;
            mul_y_s = b0;
         end
         2'b10: begin
            mul_x_s = a1;
            mul_y_s = b1;
         end
         default: begin
            mul_x_s = 4'd0;
            mul_y_s = 4'd0;
         end
      endcase
   end

   pipelined_multiplier u_mul (
      .clk (clk),
      .x   (mul_x_s),
      .y   (mul_y_s),
      .p   (mul_p_s)
   );

   // Next-state: pointer, tag pipes aligned with the multiplier, counters.
   always_comb begin
      ptr_d  = ptr_q;
      vld_d  = {vld_q[STAGES-2:0], any_grant_s};
      id_d   = {id_q[STAGES-2:0], grant_id_s};
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (any_grant_s) begin
         ptr_d = ptr_after_grant(grant_id_s);
      end else begin
         ptr_d = ptr_q;
      end
      if (vld_q[STAGES-1] && !id_q[STAGES-1]) begin
         cnt0_d = cnt0_q + CNT_ONE;
      end else begin
         cnt0_d = cnt0_q;
      end
      if (vld_q[STAGES-1] && id_q[STAGES-1]) begin
         cnt1_d = cnt1_q + CNT_ONE;
      end else begin
         cnt1_d = cnt1_q;
      end
   end

   // Control state; reset drops every in-flight tag so masked data never escapes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q  <= PTR_REQ0;
         vld_q  <= {STAGES{1'b0}};
         id_q   <= {STAGES{1'b0}};
         cnt0_q <= CNT_ZERO;
         cnt1_q <= CNT_ZERO;
      end else begin
         ptr_q  <= ptr_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign res_valid = vld_q[STAGES-1];
   assign res_id    = id_q[STAGES-1];
   assign res_data  = mul_p_s;
   assign busy      = |vld_q;
   assign done_cnt0 = cnt0_q;
   assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler; counters built with CNT_W = 2 to expose wrap.
module tb_mult_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] req_valid;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] req_ready;
   logic       res_valid;
   logic       res_id;
   logic [7:0] res_data;
   logic       busy;
   logic [1:0] done_cnt0;
   logic [1:0] done_cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult_scheduler #(.CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
      .a0        (a0),
      .b0        (b0),
      .a1        (a1),
      .b1        (b1),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy),
      .done_cnt0 (done_cnt0),
      .done_cnt1 (done_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      en = 1'b1;
      req_valid = 2'b00;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      req_valid = 2'b11;
      a0 = 4'd1; b0 = 4'd1; a1 = 4'd1; b1 = 4'd1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=00", req_ready);
      end
      checks++;
      if (res_valid !== 1'b0 || res_id !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b id=%b busy=%b exp 0/0/0", res_valid, res_id, busy);
      end
      checks++;
      if (done_cnt0 !== 2'd0 || done_cnt1 !== 2'd0) begin
         failures++;
         $display("FAIL reset_counters got=%0d/%0d exp=0/0", done_cnt0, done_cnt1);
      end
      tick();
      rst_n = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || res_id !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL post_reset got valid=%b id=%b busy=%b ready=%b exp all 0", res_valid, res_id, busy, req_ready);
      end
   endtask

   task automatic test_single_op();
      apply_reset();
      req_valid = 2'b01; a0 = 4'd7; b0 = 4'd9;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (req_ready !== 2'b01) begin
               failures++;
               $display("FAIL single_ready got=%b exp=01", req_ready);
            end
         end
         if (c == 3) begin
            checks++;
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 8'd63) begin
               failures++;
               $display("FAIL single_result c=%0d got v=%b id=%b d=%0d exp v=1 id=0 d=63", c, res_valid, res_id, res_data);
            end
         end else begin
            checks++;
            if (res_valid !== 1'b0) begin
               failures++;
               $display("FAIL single_novalid c=%0d got=%b exp=0", c, res_valid);
            end
         end
         if (c == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL single_busy got=%b exp=1", busy);
            end
         end
         if (c == 4) begin
            checks++;
            if (done_cnt0 !== 2'd1 || done_cnt1 !== 2'd0 || busy !== 1'b0) begin
               failures++;
               $display("FAIL single_done got cnt0=%0d cnt1=%0d busy=%b exp 1/0/0", done_cnt0, done_cnt1, busy);
            end
         end
         tick();
         req_valid = 2'b00;
      end
   endtask

   task automatic test_contention();
      logic       exp_id;
      logic [7:0] exp_d;
      logic [1:0] exp_g;
      apply_reset();
      a0 = 4'd3; b0 = 4'd5; a1 = 4'd15; b1 = 4'd15;
      req_valid = 2'b11;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 4) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_g) begin
               failures++;
               $display("FAIL contention_grant c=%0d got=%b exp=%b", c, req_ready, exp_g);
            end
         end
         if (c >= 3 && c <= 6) begin
            exp_id = ((c - 3) % 2 == 1) ? 1'b1 : 1'b0;
            exp_d  = exp_id ? 8'd225 : 8'd15;
            checks++;
            if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== exp_d) begin
               failures++;
               $display("FAIL contention_result c=%0d got v=%b id=%b d=%0d exp v=1 id=%b d=%0d", c, res_valid, res_id, res_data, exp_id, exp_d);
            end
         end else begin
            checks++;
            if (res_valid !== 1'b0) begin
               failures++;
               $display("FAIL contention_novalid c=%0d got=%b exp=0", c, res_valid);
            end
         end
         tick();
         if (c == 3) req_valid = 2'b00;
      end
      @(negedge clk);
      checks++;
      if (done_cnt0 !== 2'd2 || done_cnt1 !== 2'd2) begin
         failures++;
         $display("FAIL contention_counts got=%0d/%0d exp=2/2", done_cnt0, done_cnt1);
      end
   endtask

   task automatic test_enable_gating();
      apply_reset();
      en = 1'b0;
      req_valid = 2'b11;
      a0 = 4'd2; b0 = 4'd2; a1 = 4'd3; b1 = 4'd3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 2'b00 || res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_low c=%0d got ready=%b v=%b busy=%b exp 00/0/0", c, req_ready, res_valid, busy);
         end
         tick();
      end
      en = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL enable_first got=%b exp=01", req_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL enable_second got=%b exp=10", req_ready);
      end
      tick();
      req_valid = 2'b00;
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      req_valid = 2'b01; a0 = 4'd2; b0 = 4'd3;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL midflight_grant0 got=%b exp=01", req_ready);
      end
      tick();
      req_valid = 2'b10; a1 = 4'd4; b1 = 4'd5;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL midflight_grant1 got=%b exp=10", req_ready);
      end
      tick();
      req_valid = 2'b00;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 3; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== 2'd0 || done_cnt1 !== 2'd0) begin
            failures++;
            $display("FAIL midflight_flush c=%0d got v=%b busy=%b cnt=%0d/%0d exp 0/0/0/0", c, res_valid, busy, done_cnt0, done_cnt1);
         end
         tick();
      end
   endtask

   task automatic test_counter_wrap();
      logic [1:0] exp_cnt;
      logic [7:0] exp_d;
      apply_reset();
      for (int c = 0; c < 9; c++) begin
         if (c < 5) begin
            req_valid = 2'b10;
            a1 = 4'(c + 1);
            b1 = 4'd2;
         end else begin
            req_valid = 2'b00;
         end
         @(negedge clk);
         if (c < 5) begin
            checks++;
            if (req_ready !== 2'b10) begin
               failures++;
               $display("FAIL wrap_grant c=%0d got=%b exp=10", c, req_ready);
            end
         end
         if (c >= 3 && c <= 7) begin
            exp_d = 8'((c - 2) * 2);
            checks++;
            if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== exp_d) begin
               failures++;
               $display("FAIL wrap_result c=%0d got v=%b id=%b d=%0d exp v=1 id=1 d=%0d", c, res_valid, res_id, res_data, exp_d);
            end
         end
         if (c >= 4) begin
            exp_cnt = 2'((c - 3) % 4);
            checks++;
            if (done_cnt1 !== exp_cnt || done_cnt0 !== 2'd0) begin
               failures++;
               $display("FAIL wrap_count c=%0d got cnt1=%0d cnt0=%0d exp cnt1=%0d cnt0=0", c, done_cnt1, done_cnt0, exp_cnt);
            end
         end
         tick();
      end
   endtask

   task automatic test_exhaustive();
      int         results;
      int         m;
      logic       exp_id;
      logic [7:0] exp_d;
      logic [1:0] exp_g;
      results = 0;
      apply_reset();
      for (int c = 0; c < 260; c++) begin
         if (c < 256) begin
            if (c % 2 == 1) begin
               req_valid = 2'b10;
               a1 = 4'(c >> 4);
               b1 = 4'(c & 15);
            end else begin
               req_valid = 2'b01;
               a0 = 4'(c >> 4);
               b0 = 4'(c & 15);
            end
         end else begin
            req_valid = 2'b00;
         end
         @(negedge clk);
         if (c < 256) begin
            exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== exp_g) begin
               failures++;
               $display("FAIL exh_grant c=%0d got=%b exp=%b", c, req_ready, exp_g);
            end
         end
         if (res_valid === 1'b1) results++;
         if (c >= 3 && c < 259) begin
            m = c - 3;
            exp_id = (m % 2 == 1) ? 1'b1 : 1'b0;
            exp_d  = 8'((m >> 4) * (m & 15));
            checks++;
            if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== exp_d) begin
               failures++;
               $display("FAIL exh_result op=%0d got v=%b id=%b d=%0d exp v=1 id=%b d=%0d", m, res_valid, res_id, res_data, exp_id, exp_d);
            end
         end else begin
            checks++;
            if (res_valid !== 1'b0) begin
               failures++;
               $display("FAIL exh_novalid c=%0d got=%b exp=0", c, res_valid);
            end
         end
         tick();
      end
      checks++;
      if (results != 256) begin
         failures++;
         $display("FAIL exh_total got=%0d exp=256", results);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      req_valid = 2'b00;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      test_reset();
      test_single_op();
      test_contention();
      test_enable_gating();
      test_reset_midflight();
      test_counter_wrap();
      test_exhaustive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-requester completion counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  issue enable; low blocks new grants, in-flight ops still drain.
REQ-005 req_valid  input  2  per-requester operand-valid; bit i = requester i.
REQ-006 a0, b0  input  4 each  requester 0 operands (multiplicand, multiplier).
REQ-007 a1, b1  input  4 each  requester 1 operands.
REQ-008 req_ready  output  2  per-requester accept strobe; at most one bit high per cycle.
REQ-009 res_valid  output  1  result valid strobe, one cycle per completed op.
REQ-010 res_id  output  1  requester index owning the current result.
REQ-011 res_data  output  8  unsigned product.
REQ-012 busy  output  1  high while any accepted op has not yet produced res_valid.
REQ-013 done_cnt0, done_cnt1  output  CNT_W each  completed-op counters per requester.

Function
REQ-014 Handshake: op from requester i accepted in cycle T iff req_valid[i] & req_ready[i] in cycle T.
REQ-015 req_ready is combinational from req_valid, en and the priority pointer; no dependency on result side.
REQ-016 Arbitration: round-robin over 2 requesters; pointer names the preferred requester.
REQ-017 Only one requester valid and en high: that requester is granted.
REQ-018 Both valid and en high: preferred requester is granted; the other waits.
REQ-019 Pointer update: after a grant to i, pointer moves to 1-i; no grant leaves pointer unchanged.
REQ-020 en low: req_ready = 2'b00 regardless of req_valid; pointer unchanged.
REQ-021 Granted operands drive the multiplier x/y inputs in the grant cycle; no grant drives x = y = 0.
REQ-022 Latency: op accepted in cycle T produces res_valid = 1, matching res_id and res_data = a*b in cycle T+3, exact.
REQ-023 Throughput: one accept per cycle sustained; back-to-back results emerge in accept order.
REQ-024 Tracking: 3-stage valid shift register and 3-stage id shift register run parallel to the multiplier stages.
REQ-025 No result backpressure: res_valid is a one-cycle strobe; consumer captures it unconditionally.
REQ-026 res_data holds whatever the multiplier presents when res_valid = 0; consumers ignore it.
REQ-027 done_cnt_i increments by 1 in each cycle where res_valid = 1 and res_id = i; wraps from all-ones to 0.
REQ-028 busy = OR of the 3 valid-pipe bits; it does not include the accept cycle itself.
REQ-029 Operand width rule: 4x4 unsigned, full 8-bit product, no truncation or saturation (15*15 = 225).

Reset
REQ-030 rst_n sampled low at a rising edge clears: valid pipe, id pipe, pointer (-> requester 0), done_cnt0/1 (-> 0).
REQ-031 During and in the first cycle after reset: req_ready = 0, res_valid = 0, res_id = 0, busy = 0.
REQ-032 Reset mid-operation: in-flight ops are discarded, with no res_valid for them; multiplier data stages are not reset and are masked by the valid pipe.
REQ-033 The first grant is possible in the first cycle with rst_n high after reset.

Structure
REQ-034 The shared package holds: STAGES = 3 (multiplier latency), NREQ = 2, operand width 4, product width 8.
REQ-035 One sub-module: the existing 3-stage 4x4 pipelined_multiplier, instantiated unmodified on clk.
REQ-036 Arbiter, operand mux, tracking pipes and counters live in mult_scheduler itself.

Verification
REQ-037 Single op: reset, then req_valid = 01, a0 = 7, b0 = 9 for one cycle T -> res_valid only in T+3, res_id = 0, res_data = 63, done_cnt0 = 1.
REQ-038 Contention: both valid for 4 cycles, a0/b0 = 3/5 and a1/b1 = 15/15 -> grants 0,1,0,1; results 15,225,15,225 in T+3..T+6 with ids 0,1,0,1.
REQ-039 Enable gating: both valid with en = 0 for 5 cycles -> req_ready = 00 throughout and pointer unchanged; en = 1 -> requester 0 is granted first.
REQ-040 Reset mid-flight: accept ops in cycles T and T+1, assert rst_n = 0 in T+2 -> no res_valid in T+3/T+4, counters 0, busy 0.
REQ-041 Counter wrap (CNT_W = 2): 5 ops from requester 1 -> done_cnt1 sequence 1,2,3,0,1; done_cnt0 stays 0.
REQ-042 Exhaustive: all 256 operand pairs streamed from alternating requesters -> every res_data = a*b with the correct res_id, 256 results total.
